vline_fetch: RTL and testbench
==============================

VLINE_FETCH -- requirements
Module: vline_fetch

Interface
REQ-001 Parameter LINE_LEN, default 640: bytes fetched per scanline.
REQ-002 Parameter FIFO_DEPTH, default 16: pixel buffer entries, power of two.
REQ-003 MemClk  in  1  single clock; all state updates on posedge.
REQ-004 ResetN  in  1  asynchronous, active-low reset.
REQ-005 LineStart  in  1  one-cycle pulse; begin fetch of a new line.
REQ-006 LineBase  in  19  first byte address of the line; sampled on LineStart.
REQ-007 ReqAddr  out  19  read address presented to the vmmu request source port.
REQ-008 ReqReadData  in  8  read data returned by vmmu.
REQ-009 ReadDataRdy  in  1  one-cycle strobe; ReqReadData is valid for ReqAddr.
REQ-010 PixelData  out  8  FIFO head byte, first-word-fall-through.
REQ-011 PixelValid  out  1  FIFO not empty.
REQ-012 PixelPop  in  1  consumer takes PixelData this cycle.
REQ-013 LineDone  out  1  all LINE_LEN bytes accepted into the FIFO.
REQ-014 Underflow  out  1  sticky; pop attempted while empty.

Function
REQ-015 FSM states: IDLE, FETCH, WAIT_SPACE, DONE.
REQ-016 IDLE -> FETCH on LineStart: ReqAddr <= LineBase, byte count <= 0, FIFO flushed, Underflow cleared, LineDone cleared.
REQ-017 In FETCH, ReqAddr holds stable until ReadDataRdy=1.
REQ-018 In FETCH with ReadDataRdy=1: push ReqReadData, ReqAddr += 1, count += 1.
REQ-019 ReqAddr increment wraps modulo 2^19 (0x7FFFF -> 0x00000).
REQ-020 FETCH -> DONE when the push brings count to LINE_LEN; LineDone=1 from the next cycle until LineStart or reset.
REQ-021 FETCH -> WAIT_SPACE when the push makes the FIFO full with no same-cycle pop.
REQ-022 WAIT_SPACE -> FETCH on the first cycle the FIFO level < FIFO_DEPTH.
REQ-023 ReadDataRdy is ignored in IDLE, WAIT_SPACE and DONE; no push, no address change.
REQ-024 Push on full FIFO is accepted only when PixelPop=1 in the same cycle; the level is unchanged.
REQ-025 Pop on an empty FIFO: no state change except Underflow <= 1; PixelData holds its last value.
REQ-026 Simultaneous push and pop on an empty FIFO: the pop sets Underflow; the pushed byte is retained.
REQ-027 Latency: ReadDataRdy at cycle n into an empty FIFO gives PixelValid=1 and PixelData=byte at cycle n+1.
REQ-028 LineStart in any state (mid-line included) restarts per REQ-016; an unpopped FIFO is discarded.
REQ-029 ReadDataRdy coincident with LineStart is discarded.

Reset
REQ-030 ResetN=0 forces IDLE immediately; ReqAddr=0, count=0, FIFO empty, PixelValid=0, PixelData=0, LineDone=0, Underflow=0.
REQ-031 Deassertion is synchronised externally; the block needs no internal reset synchroniser.

Structure
REQ-032 A shared package vga_pkg holds ADDR_W=19, DATA_W=8 and the FSM state encoding.
REQ-033 FIFO storage and pointers form one sub-module vfifo (sync, FWFT, level output); the FSM and address counter stay in vline_fetch.
REQ-034 The block contains no tri-states and no combinational path from PixelPop to ReqAddr.

Verification
REQ-035 Reset, then LineStart with LineBase=0x00100 and LINE_LEN=4, ReadDataRdy every third cycle with data 0xA0..0xA3, PixelPop tied high -> ReqAddr steps 0x100..0x103, pixels come out A0,A1,A2,A3 in order, LineDone=1, Underflow=0.
REQ-036 FIFO_DEPTH=16, LINE_LEN=40, ReadDataRdy every cycle, no pops -> WAIT_SPACE entered at level 16, ReqAddr frozen at LineBase+16; after 4 pops, fetch resumes and the level returns to 16.
REQ-037 LineBase=0x7FFFE, LINE_LEN=4 -> ReqAddr sequence 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
REQ-038 Pop while empty right after LineStart -> Underflow=1 sticky through the line; the next LineStart clears it.
REQ-039 LineStart mid-line at count 7 with 5 bytes buffered -> FIFO empty next cycle, ReqAddr=new LineBase, count restarts at 0.
REQ-040 ResetN asserted asynchronously mid-FETCH -> all outputs at REQ-030 values before the next MemClk edge.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared widths and scanline-fetch FSM encoding for the VGA pixel path.
package vga_pkg;
   localparam int ADDR_W = 19;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      FETCH      = 2'd1,
      WAIT_SPACE = 2'd2,
      DONE       = 2'd3
   } fetchState_t;
endpackage

// File: rtl/vfifo.sv
// Purpose: synchronous first-word-fall-through byte FIFO with flush and level output.
// Latency: a pushed word is visible at popData the cycle after the push.
// Backpressure: push on full is taken only alongside a pop; pop on empty is ignored.
module vfifo import vga_pkg::*; #(
   parameter int DEPTH = 16,
   parameter int WIDTH = DATA_W
) (
   input  logic                       clk,
   input  logic                       rstN,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           pushData,
   input  logic                       pop,
   output logic [WIDTH-1:0]           popData,
   output logic                       notEmpty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wrPtr, rdPtr;
   logic [WIDTH-1:0] lastQ;
   logic             doPush, doPop;

   assign level    = wrPtr - rdPtr;
   assign notEmpty = (wrPtr != rdPtr);
   assign full     = (level == (AW+1)'(DEPTH));
   assign doPop    = pop & notEmpty;
   assign doPush   = push & (~full | pop);

   // When empty the output holds the last byte handed out.
   assign popData  = notEmpty ? mem[rdPtr[AW-1:0]] : lastQ;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         wrPtr <= '0;
         rdPtr <= '0;
         lastQ <= '0;
      end else if (flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
         if (doPop) begin
            rdPtr <= rdPtr + (AW+1)'(1);
            lastQ <= mem[rdPtr[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (doPush && !flush) mem[wrPtr[AW-1:0]] <= pushData;
   end
endmodule

// File: rtl/vline_fetch.sv
// Purpose: fetches LINE_LEN bytes of a scanline from vmmu into a pixel FIFO.
// Latency: a ReadDataRdy byte reaches PixelData one cycle later (empty FIFO).
// Backpressure: fetching pauses in WAIT_SPACE while the FIFO is full.
module vline_fetch import vga_pkg::*; #(
   parameter int LINE_LEN   = 640,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              MemClk,
   input  logic              ResetN,
   input  logic              LineStart,
   input  logic [ADDR_W-1:0] LineBase,
   output logic [ADDR_W-1:0] ReqAddr,
   input  logic [DATA_W-1:0] ReqReadData,
   input  logic              ReadDataRdy,
   output logic [DATA_W-1:0] PixelData,
   output logic              PixelValid,
   input  logic              PixelPop,
   output logic              LineDone,
   output logic              Underflow
);
   localparam int CW = $clog2(LINE_LEN + 1);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] LAST_CNT    = CW'(LINE_LEN - 1);
   localparam logic [LW-1:0] ALMOST_FULL = LW'(FIFO_DEPTH - 1);

   fetchState_t   state, stateNext;
   logic [CW-1:0] byteCnt;
   logic          underflowQ;
   logic          fifoFull;
   logic [LW-1:0] fifoLevel;
   logic          pushReq, pushOk, fillsUp;

   // A restart pulse discards any byte returned in the same cycle.
   assign pushReq = (state == FETCH) & ReadDataRdy & ~LineStart;
   assign pushOk  = pushReq & (~fifoFull | PixelPop);
   assign fillsUp = (fifoLevel == ALMOST_FULL) & ~(PixelPop & PixelValid);

   always_comb begin
      stateNext = state;
      if (LineStart) begin
         stateNext = FETCH;
      end else begin
         case (state)
            FETCH: begin
               if (pushOk) begin
                  if (byteCnt == LAST_CNT) stateNext = DONE;
                  else if (fillsUp)        stateNext = WAIT_SPACE;
               end
            end
            WAIT_SPACE: if (!fifoFull) stateNext = FETCH;
            default: ;
         endcase
      end
   end

   always_ff @(posedge MemClk or negedge ResetN) begin
      if (!ResetN) begin
         state      <= IDLE;
         ReqAddr    <= '0;
         byteCnt    <= '0;
         underflowQ <= 1'b0;
      end else begin
         state <= stateNext;
         if (LineStart) begin
            ReqAddr    <= LineBase;
            byteCnt    <= '0;
            underflowQ <= 1'b0;
         end else begin
            if (pushOk) begin
               ReqAddr <= ReqAddr + ADDR_W'(1);
               byteCnt <= byteCnt + CW'(1);
            end
            if (PixelPop && !PixelValid) underflowQ <= 1'b1;
         end
      end
   end

   assign LineDone  = (state == DONE);
   assign Underflow = underflowQ;

   vfifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) pixFifo (
      .clk      (MemClk),
      .rstN     (ResetN),
      .flush    (LineStart),
      .push     (pushReq),
      .pushData (ReqReadData),
      .pop      (PixelPop),
      .popData  (PixelData),
      .notEmpty (PixelValid),
      .full     (fifoFull),
      .level    (fifoLevel)
   );
endmodule

// File: tb/tb_vline_fetch.sv
// Directed bench: short-line instance (LINE_LEN=4) and long-line instance (LINE_LEN=40).
module tb_vline_fetch;
   logic        MemClk;
   logic        ResetN;
   logic        LineStart;
   logic [18:0] LineBase;
   logic        ReadDataRdy;

   logic [18:0] ReqAddrA, ReqAddrB;
   logic [7:0]  ReqReadDataA, ReqReadDataB;
   logic [7:0]  PixelDataA, PixelDataB;
   logic        PixelValidA, PixelValidB;
   logic        PixelPopA, PixelPopB;
   logic        LineDoneA, LineDoneB;
   logic        UnderflowA, UnderflowB;
   logic        autoPopB, popB;

   int errCnt = 0;
   int chkCnt = 0;

   function automatic logic [7:0] dataFn(input logic [18:0] a);
      return a[7:0] + 8'hA0;
   endfunction

   assign ReqReadDataA = dataFn(ReqAddrA);
   assign ReqReadDataB = dataFn(ReqAddrB);
   assign PixelPopA    = PixelValidA;
   assign PixelPopB    = autoPopB ? PixelValidB : popB;

   vline_fetch #(.LINE_LEN(4), .FIFO_DEPTH(16)) dutA (
      .MemClk(MemClk), .ResetN(ResetN), .LineStart(LineStart), .LineBase(LineBase),
      .ReqAddr(ReqAddrA), .ReqReadData(ReqReadDataA), .ReadDataRdy(ReadDataRdy),
      .PixelData(PixelDataA), .PixelValid(PixelValidA), .PixelPop(PixelPopA),
      .LineDone(LineDoneA), .Underflow(UnderflowA)
   );

   vline_fetch #(.LINE_LEN(40), .FIFO_DEPTH(16)) dutB (
      .MemClk(MemClk), .ResetN(ResetN), .LineStart(LineStart), .LineBase(LineBase),
      .ReqAddr(ReqAddrB), .ReqReadData(ReqReadDataB), .ReadDataRdy(ReadDataRdy),
      .PixelData(PixelDataB), .PixelValid(PixelValidB), .PixelPop(PixelPopB),
      .LineDone(LineDoneB), .Underflow(UnderflowB)
   );

   initial MemClk = 1'b0;
   always #5 MemClk = ~MemClk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chkCnt++;
      if (got !== exp) begin
         errCnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge MemClk);
      #1;
   endtask

   task automatic startLine(input logic [18:0] base);
      LineBase  = base;
      LineStart = 1'b1;
      tick();
      LineStart = 1'b0;
   endtask

   logic [18:0] wrapSeq [4];

   initial begin
      wrapSeq[0] = 19'h7FFFE;
      wrapSeq[1] = 19'h7FFFF;
      wrapSeq[2] = 19'h00000;
      wrapSeq[3] = 19'h00001;

      ResetN = 1'b1; LineStart = 1'b0; LineBase = '0; ReadDataRdy = 1'b0;
      autoPopB = 1'b0; popB = 1'b0;
      #1 ResetN = 1'b0;
      #1;
      chk("rstAddr",   32'(ReqAddrA),    32'h0);
      chk("rstValid",  32'(PixelValidA), 32'h0);
      chk("rstData",   32'(PixelDataA),  32'h0);
      chk("rstDone",   32'(LineDoneA),   32'h0);
      chk("rstUfl",    32'(UnderflowA),  32'h0);
      tick(); tick();
      ResetN = 1'b1;

      // Idle ignores returned data
      ReadDataRdy = 1'b1;
      tick(); tick();
      ReadDataRdy = 1'b0;
      chk("idleAddr",  32'(ReqAddrA),    32'h0);
      chk("idleValid", 32'(PixelValidA), 32'h0);

      // Basic line: strobe every third cycle, consumer always ready
      startLine(19'h00100);
      for (int i = 0; i < 4; i++) begin
         tick(); tick();
         chk("slowAddr", 32'(ReqAddrA), 32'h100 + i);
         ReadDataRdy = 1'b1;
         tick();
         ReadDataRdy = 1'b0;
         chk("slowValid", 32'(PixelValidA), 32'h1);
         chk("slowPix",   32'(PixelDataA),  32'hA0 + i);
      end
      chk("slowDone", 32'(LineDoneA),  32'h1);
      chk("slowUfl",  32'(UnderflowA), 32'h0);
      ReadDataRdy = 1'b1;
      tick();
      ReadDataRdy = 1'b0;
      tick();
      chk("doneIgnAddr", 32'(ReqAddrA),    32'h104);
      chk("doneDrained", 32'(PixelValidA), 32'h0);

      // Address wrap at the top of the space
      startLine(19'h7FFFE);
      ReadDataRdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("wrapAddr", 32'(ReqAddrA), 32'(wrapSeq[i]));
         tick();
      end
      ReadDataRdy = 1'b0;
      chk("wrapDone",  32'(LineDoneA), 32'h1);
      chk("wrapFinal", 32'(ReqAddrA),  32'h2);

      // Fill to full, stall, resume after four pops
      startLine(19'h00200);
      ReadDataRdy = 1'b1;
      repeat (16) tick();
      chk("fullAddr", 32'(ReqAddrB), 32'h210);
      repeat (3) tick();
      chk("waitFrozen", 32'(ReqAddrB), 32'h210);
      popB = 1'b1;
      repeat (4) tick();
      popB = 1'b0;
      repeat (6) tick();
      chk("resumeAddr", 32'(ReqAddrB), 32'h214);
      ReadDataRdy = 1'b0;
      popB = 1'b1;
      for (int k = 0; k < 16; k++) begin
         chk("drainPix", 32'(PixelDataB), 32'(dataFn(19'(32'h204 + k))));
         tick();
      end
      popB = 1'b0;
      chk("drainEmpty", 32'(PixelValidB), 32'h0);
      chk("drainUfl",   32'(UnderflowB),  32'h0);

      // Pop and push together on an empty FIFO, sticky underflow
      startLine(19'h00300);
      ReadDataRdy = 1'b1;
      popB = 1'b1;
      tick();
      popB = 1'b0;
      chk("uflSet",    32'(UnderflowB),  32'h1);
      chk("uflKeepV",  32'(PixelValidB), 32'h1);
      chk("uflKeepD",  32'(PixelDataB),  32'hA0);
      repeat (3) tick();
      ReadDataRdy = 1'b0;
      chk("uflSticky", 32'(UnderflowB), 32'h1);
      chk("uflAddr",   32'(ReqAddrB),   32'h304);
      startLine(19'h00400);
      chk("uflClear",  32'(UnderflowB),  32'h0);
      chk("uflFlush",  32'(PixelValidB), 32'h0);

      // Restart mid-line with bytes buffered
      ReadDataRdy = 1'b1;
      repeat (7) tick();
      ReadDataRdy = 1'b0;
      popB = 1'b1;
      repeat (2) tick();
      popB = 1'b0;
      chk("midAddr", 32'(ReqAddrB),   32'h407);
      chk("midHead", 32'(PixelDataB), 32'hA2);
      ReadDataRdy = 1'b1;
      startLine(19'h00500);
      chk("restartEmpty", 32'(PixelValidB), 32'h0);
      chk("restartAddr",  32'(ReqAddrB),    32'h500);
      autoPopB = 1'b1;
      tick();
      chk("restartAddr1", 32'(ReqAddrB),    32'h501);
      chk("restartPix",   32'(PixelDataB),  32'hA0);
      chk("restartValid", 32'(PixelValidB), 32'h1);
      repeat (38) tick();
      chk("cnt39Done", 32'(LineDoneB), 32'h0);
      tick();
      chk("cnt40Done", 32'(LineDoneB), 32'h1);
      chk("cnt40Addr", 32'(ReqAddrB),  32'h528);
      ReadDataRdy = 1'b0;
      autoPopB = 1'b0;

      // Asynchronous reset in the middle of a fetch
      startLine(19'h00600);
      ReadDataRdy = 1'b1;
      popB = 1'b1;
      tick();
      popB = 1'b0;
      tick(); tick();
      chk("preRstUfl", 32'(UnderflowB), 32'h1);
      #2 ResetN = 1'b0;
      #1;
      chk("arstAddr",  32'(ReqAddrB),    32'h0);
      chk("arstValid", 32'(PixelValidB), 32'h0);
      chk("arstData",  32'(PixelDataB),  32'h0);
      chk("arstDone",  32'(LineDoneB),   32'h0);
      chk("arstUfl",   32'(UnderflowB),  32'h0);
      ReadDataRdy = 1'b0;
      tick();
      ResetN = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end
endmodule
